alu_seq: RTL and testbench

- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Width is generic and operands are captured by a start/busy/done handshake.
- Results and flags are registered. Adds a multi-cycle shift-add multiplier, an internal accumulator, and Zero/Overflow flags.
- Sits between the operand register file and the datapath controller, which issues one operation at a time.

---
 rtl/alu_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : registered, width-generic ALU with a start/busy/done handshake.
//
// Operands are captured when start is seen in IDLE. Single-cycle ops are
// evaluated in EXEC. MUL runs a shift-add multiplier, one bit of B per cycle.
// The result is staged and then published to the outputs on the edge that
// leaves DONE, which is also the edge that raises the done pulse. The
// outputs therefore change exactly when done is seen.
//
// Ports
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-high reset
//   start     : operation request, sampled only in IDLE
//   A, B      : operands (WORD_LENGTH bits)
//   Ctrl      : 4-bit opcode
//   shifter   : serial bit shifted in by SHL/SHR
//   C         : result (low half for MUL)
//   C_hi      : high half for MUL, 0 otherwise
//   Carry     : carry / borrow / shifted-out bit
//   Zero      : {C_hi,C} == 0
//   Overflow  : two's-complement overflow for ADD/SUB/INC/DEC
//   busy      : high from capture until the result is published
//   done      : one-cycle pulse when the outputs update
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int WORD_LENGTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WORD_LENGTH-1:0] A,
   input  logic [WORD_LENGTH-1:0] B,
   input  logic [3:0]             Ctrl,
   input  logic                   shifter,
   output logic [WORD_LENGTH-1:0] C,
   output logic [WORD_LENGTH-1:0] C_hi,
   output logic                   Carry,
   output logic                   Zero,
   output logic                   Overflow,
   output logic                   busy,
   output logic                   done
);

   localparam int W  = WORD_LENGTH;
   localparam int CW = $clog2(W + 1);
   localparam logic [W:0]    ONE_W1 = (W + 1)'(1);
   localparam logic [W-1:0]  ONE_W  = W'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(W);
   localparam logic [3:0]    OP_MUL = 4'd12;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

   state_t r_state;
   state_t w_state_next;

   logic [W-1:0]   r_a, r_b, r_acc;
   logic [3:0]     r_op;
   logic           r_sh;
   logic [2*W-1:0] r_prod;
   logic [CW-1:0]  r_cnt;

   // Staged result, published to the outputs when DONE is left.
   logic [W-1:0]   r_st_c, r_st_hi;
   logic           r_st_carry, r_st_ovf;

   logic [W:0]     w_add, w_sub, w_inc, w_dec, w_acc, w_mul_sum;
   logic [W-1:0]   w_c;
   logic           w_carry, w_ovf;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_state_next = (Ctrl == OP_MUL) ? S_MUL : S_EXEC;
         S_EXEC: w_state_next = S_DONE;
         S_MUL:  if (r_cnt == CNT_LAST) w_state_next = S_DONE;
         S_DONE: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------- single-cycle datapath ----------------
   // Extended by one bit so the MSB is the carry-out / borrow.
   assign w_add = {1'b0, r_a} + {1'b0, r_b};
   assign w_sub = {1'b0, r_a} - {1'b0, r_b};
   assign w_inc = {1'b0, r_a} + ONE_W1;
   assign w_dec = {1'b0, r_a} - ONE_W1;
   assign w_acc = {1'b0, r_acc} + {1'b0, r_a};

   always_comb begin
      w_c     = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      case (r_op)
         4'd0: begin
            w_c     = w_add[W-1:0];
            w_carry = w_add[W];
            w_ovf   = (r_a[W-1] == r_b[W-1]) && (w_add[W-1] != r_a[W-1]);
         end
         4'd1: begin
            w_c     = w_sub[W-1:0];
            w_carry = w_sub[W];
            w_ovf   = (r_a[W-1] != r_b[W-1]) && (w_sub[W-1] != r_a[W-1]);
         end
         4'd2: w_c = r_a & r_b;
         4'd3: w_c = r_a | r_b;
         4'd4: w_c = r_a ^ r_b;
         4'd5: w_c = ~r_a;
         4'd6: begin
            w_c     = {r_a[W-2:0], r_sh};
            w_carry = r_a[W-1];
         end
         4'd7: begin
            w_c     = {r_sh, r_a[W-1:1]};
            w_carry = r_a[0];
         end
         4'd8: begin
            w_c     = {r_a[W-2:0], r_a[W-1]};
            w_carry = r_a[W-1];
         end
         4'd9: begin
            w_c     = {r_a[0], r_a[W-1:1]};
            w_carry = r_a[0];
         end
         4'd10: begin
            w_c     = w_inc[W-1:0];
            w_carry = w_inc[W];
            w_ovf   = ~r_a[W-1] & w_inc[W-1];
         end
         4'd11: begin
            w_c     = w_dec[W-1:0];
            w_carry = w_dec[W];
            w_ovf   = r_a[W-1] & ~w_dec[W-1];
         end
         4'd13: w_c = (r_a < r_b) ? ONE_W : '0;
         4'd14: w_c = r_b;
         4'd15: begin
            w_c     = w_acc[W-1:0];
            w_carry = w_acc[W];
         end
         default: ;
      endcase
   end

   // Shift-add step: the multiplier lives in the low half of r_prod and is
   // consumed from bit 0 while the partial product grows from the top.
   assign w_mul_sum = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_a} : '0);

   // ---------------- registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= '0;
         r_sh       <= 1'b0;
         r_acc      <= '0;
         r_prod     <= '0;
         r_cnt      <= '0;
         r_st_c     <= '0;
         r_st_hi    <= '0;
         r_st_carry <= 1'b0;
         r_st_ovf   <= 1'b0;
         C          <= '0;
         C_hi       <= '0;
         Carry      <= 1'b0;
         Zero       <= 1'b1;
         Overflow   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a    <= A;
                  r_b    <= B;
                  r_op   <= Ctrl;
                  r_sh   <= shifter;
                  r_prod <= {{W{1'b0}}, B};
                  r_cnt  <= '0;
                  busy   <= 1'b1;
               end
            end
            S_EXEC: begin
               r_st_c     <= w_c;
               r_st_hi    <= '0;
               r_st_carry <= w_carry;
               r_st_ovf   <= w_ovf;
               if (r_op == 4'd15) r_acc <= w_acc[W-1:0];
            end
            S_MUL: begin
               if (r_cnt != CNT_LAST) begin
                  r_prod <= {w_mul_sum, r_prod[W-1:1]};
                  r_cnt  <= r_cnt + CW'(1);
               end else begin
                  r_st_c     <= r_prod[W-1:0];
                  r_st_hi    <= r_prod[2*W-1:W];
                  r_st_carry <= 1'b0;
                  r_st_ovf   <= 1'b0;
               end
            end
            S_DONE: begin
               C        <= r_st_c;
               C_hi     <= r_st_hi;
               Carry    <= r_st_carry;
               Overflow <= r_st_ovf;
               Zero     <= ({r_st_hi, r_st_c} == '0);
               busy     <= 1'b0;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : directed self-checking bench for alu_seq at WORD_LENGTH=4.
// Every expected value below is hand-computed.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] A, B, Ctrl;
   logic       shifter;
   logic [3:0] C, C_hi;
   logic       Carry, Zero, Overflow, busy, done;

   int n_cmp  = 0;
   int n_fail = 0;
   int ndone;
   int lat;

   alu_seq #(.WORD_LENGTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .Ctrl(Ctrl),
      .shifter(shifter), .C(C), .C_hi(C_hi), .Carry(Carry), .Zero(Zero),
      .Overflow(Overflow), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issue one operation, wait (bounded) for done, check latency and results.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic sh, input int exp_lat,
                         input logic [3:0] ec, input logic [3:0] ehi, input logic ecy,
                         input logic ez, input logic eov);
      int l;
      bit seen;
      @(negedge clk);
      Ctrl = op; A = a; B = b; shifter = sh; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      l = 0;
      seen = 0;
      while (!seen && l < 20) begin
         @(posedge clk);
         #1 l++;
         if (done) seen = 1;
      end
      chk({tag, ".latency"}, l, exp_lat);
      chk({tag, ".C"}, C, ec);
      chk({tag, ".C_hi"}, C_hi, ehi);
      chk({tag, ".Carry"}, Carry, ecy);
      chk({tag, ".Zero"}, Zero, ez);
      chk({tag, ".Overflow"}, Overflow, eov);
      chk({tag, ".busy"}, busy, 0);
      $display("op %-8s ctrl=%0d A=%0d B=%0d sh=%0d -> C=%0d C_hi=%0d Cy=%0d Z=%0d V=%0d lat=%0d",
               tag, op, a, b, sh, C, C_hi, Carry, Zero, Overflow, l);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; A = '0; B = '0; Ctrl = '0; shifter = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.C", C, 0);
      chk("rst.C_hi", C_hi, 0);
      chk("rst.Carry", Carry, 0);
      chk("rst.Zero", Zero, 1);
      chk("rst.Overflow", Overflow, 0);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      $display("reset state C=%0d C_hi=%0d Z=%0d busy=%0d done=%0d", C, C_hi, Zero, busy, done);
      @(negedge clk) reset = 1'b0;

      // Accumulator from reset
      run_op("acc9a", 4'd15, 4'd9, 4'd0, 1'b0, 2, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0);
      run_op("acc9b", 4'd15, 4'd9, 4'd0, 1'b0, 2, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
      run_op("passb3", 4'd14, 4'd0, 4'd3, 1'b0, 2, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
      run_op("acc1", 4'd15, 4'd1, 4'd0, 1'b0, 2, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);

      // Arithmetic / logic / shifts
      run_op("add7+9", 4'd0, 4'd7, 4'd9, 1'b0, 2, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
      run_op("add7+1", 4'd0, 4'd7, 4'd1, 1'b0, 2, 4'd8, 4'd0, 1'b0, 1'b0, 1'b1);
      run_op("sub4-3", 4'd1, 4'd4, 4'd3, 1'b0, 2, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
      run_op("sub3-4", 4'd1, 4'd3, 4'd4, 1'b0, 2, 4'd15, 4'd0, 1'b1, 1'b0, 1'b0);
      run_op("sub8-1", 4'd1, 4'd8, 4'd1, 1'b0, 2, 4'd7, 4'd0, 1'b0, 1'b0, 1'b1);
      run_op("and", 4'd2, 4'd12, 4'd10, 1'b0, 2, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0);
      run_op("or", 4'd3, 4'd12, 4'd10, 1'b0, 2, 4'd14, 4'd0, 1'b0, 1'b0, 1'b0);
      run_op("xor", 4'd4, 4'd12, 4'd10, 1'b0, 2, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0);
      run_op("not5", 4'd5, 4'd5, 4'd0, 1'b0, 2, 4'd10, 4'd0, 1'b0, 1'b0, 1'b0);
      run_op("shl5", 4'd6, 4'd5, 4'd0, 1'b1, 2, 4'd11, 4'd0, 1'b0, 1'b0, 1'b0);
      run_op("shr6", 4'd7, 4'd6, 4'd0, 1'b1, 2, 4'd11, 4'd0, 1'b0, 1'b0, 1'b0);
      run_op("rol9", 4'd8, 4'd9, 4'd0, 1'b0, 2, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0);
      run_op("ror5", 4'd9, 4'd5, 4'd0, 1'b0, 2, 4'd10, 4'd0, 1'b1, 1'b0, 1'b0);
      run_op("inc7", 4'd10, 4'd7, 4'd0, 1'b0, 2, 4'd8, 4'd0, 1'b0, 1'b0, 1'b1);
      run_op("inc15", 4'd10, 4'd15, 4'd0, 1'b0, 2, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
      run_op("dec0", 4'd11, 4'd0, 4'd0, 1'b0, 2, 4'd15, 4'd0, 1'b1, 1'b0, 1'b0);
      run_op("dec8", 4'd11, 4'd8, 4'd0, 1'b0, 2, 4'd7, 4'd0, 1'b0, 1'b0, 1'b1);
      run_op("ltu3<4", 4'd13, 4'd3, 4'd4, 1'b0, 2, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
      run_op("ltu4<3", 4'd13, 4'd4, 4'd3, 1'b0, 2, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);

      // Multiplier
      run_op("mul7*6", 4'd12, 4'd7, 4'd6, 1'b0, 6, 4'd10, 4'd2, 1'b0, 1'b0, 1'b0);
      run_op("mul0*9", 4'd12, 4'd0, 4'd9, 1'b0, 6, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      run_op("mul15*15", 4'd12, 4'd15, 4'd15, 1'b0, 6, 4'd1, 4'd14, 1'b0, 1'b0, 1'b0);

      // start storm during MUL: only the first capture counts
      @(negedge clk);
      Ctrl = 4'd12; A = 4'd7; B = 4'd6; shifter = 1'b0; start = 1'b1;
      @(posedge clk);
      ndone = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         A = 4'($urandom_range(15)); B = 4'($urandom_range(15));
         Ctrl = 4'(i); start = 1'b1;
         @(posedge clk);
         #1;
         if (done) ndone++;
         if (i < 6) chk("storm.busy", busy, 1);
      end
      chk("storm.C", C, 10);
      chk("storm.C_hi", C_hi, 2);
      @(negedge clk) start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1 if (done) ndone++;
      end
      chk("storm.ndone", ndone, 1);
      $display("storm MUL 7*6 -> C=%0d C_hi=%0d dones=%0d", C, C_hi, ndone);

      // Back-to-back: run_op issues start in the cycle right after done
      run_op("add5+6", 4'd0, 4'd5, 4'd6, 1'b0, 2, 4'd11, 4'd0, 1'b0, 1'b0, 1'b1);
      run_op("passb0", 4'd14, 4'd9, 4'd0, 1'b0, 2, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      run_op("add5+6b", 4'd0, 4'd5, 4'd6, 1'b0, 2, 4'd11, 4'd0, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of a MUL
      @(negedge clk);
      Ctrl = 4'd12; A = 4'd7; B = 4'd6; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("abort.C", C, 0);
      chk("abort.C_hi", C_hi, 0);
      chk("abort.Zero", Zero, 1);
      chk("abort.Overflow", Overflow, 0);
      chk("abort.busy", busy, 0);
      $display("abort reset C=%0d C_hi=%0d Z=%0d busy=%0d", C, C_hi, Zero, busy);
      @(negedge clk) reset = 1'b0;
      ndone = 0;
      repeat (8) begin
         @(posedge clk);
         #1 if (done) ndone++;
      end
      chk("abort.ndone", ndone, 0);
      run_op("add4+4", 4'd0, 4'd4, 4'd4, 1'b0, 2, 4'd8, 4'd0, 1'b0, 1'b0, 1'b1);
      run_op("accclr", 4'd15, 4'd1, 4'd0, 1'b0, 2, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
